// File: rtl/zion_basic_circuit_lib_vld_rdy_reg_slice_if.sv
// Valid/ready bus for the register slice. Signal names follow the slice's
// port naming: i* are driven into the slice, o* are driven by the slice.
// The master modport is the environment side and the slice uses the slave modport.
interface zion_basic_circuit_lib_vld_rdy_reg_slice_if #(
    parameter int WIDTH = 8
);
    logic             iVld;
    logic             oRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             iRdy;
    logic [WIDTH-1:0] oDat;

    modport master (
        output iVld, iDat, iRdy,
        input  oRdy, oVld, oDat
    );

    modport slave (
        input  iVld, iDat, iRdy,
        output oRdy, oVld, oDat
    );
endinterface

// File: rtl/zion_basic_circuit_lib_vld_rdy_reg_slice.sv
// Two-entry valid/ready register slice (main + skid register).
// Full throughput, registered oRdy and one cycle of latency. It cuts the
// combinational valid and ready paths between two pipeline stages.
// Optional feature: define ZION_REGSLICE_STALL_CNT_EN to add oStallCnt, a
// saturating 16-bit count of cycles with oVld & !iRdy.
module zion_basic_circuit_lib_vld_rdy_reg_slice #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic clk,
    input  logic rst,
    input  logic iClr,
    zion_basic_circuit_lib_vld_rdy_reg_slice_if.slave bus
`ifdef ZION_REGSLICE_STALL_CNT_EN
    ,
    output logic [15:0] oStallCnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic             acc, pop;
    logic             vld;

    assign vld      = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign acc      = bus.iVld & rdy_q;
    assign pop      = vld & bus.iRdy;
    assign bus.oVld = vld;
    assign bus.oRdy = rdy_q;
    assign bus.oDat = main_q;

    // Next-state logic: the main register always holds the head word and the
    // skid register catches the word that arrives while the head is stalled.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    main_d  = bus.iDat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    main_d = bus.iDat;
                end else if (acc) begin
                    skid_d  = bus.iDat;
                    state_d = ST_FULL;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // oRdy is low here, so nothing can be accepted.
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Flush drops everything, including a word offered in this cycle.
        if (iClr) begin
            state_d = ST_EMPTY;
            main_d  = INI_DATA;
            skid_d  = INI_DATA;
        end
        rdy_d = iClr ? 1'b1 : (state_d != ST_FULL);
    end

    // State and data registers. rdy_q stays low during reset and rises on the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= INI_DATA;
            skid_q  <= INI_DATA;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

`ifdef ZION_REGSLICE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign oStallCnt = stall_cnt_q;

    // Count the cycles where a word is waiting on downstream, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (iClr) begin
            stall_cnt_d = 16'd0;
        end else if (vld && !bus.iRdy && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
